// File: rtl/jtdsp16_prog_loader_if.sv
// Download-stream / ROM-programming bus between the system downloader and
// jtdsp16_prog_loader.
//   dl_en      download session active
//   dl_addr    byte address of the current download byte
//   dl_data    download byte
//   dl_wr      one-cycle strobe qualifying dl_addr/dl_data
//   prog_addr  word address into the DSP16 internal ROM
//   prog_data  16-bit word for the DSP16 internal ROM
//   prog_we    one-cycle ROM write strobe
// master = download side, slave = loader.
interface jtdsp16_prog_loader_if #(
  parameter int AW = 12
);
  logic          dl_en;
  logic [24:0]   dl_addr;
  logic [7:0]    dl_data;
  logic          dl_wr;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic          prog_we;

  modport master (
    output dl_en, dl_addr, dl_data, dl_wr,
    input  prog_addr, prog_data, prog_we
  );

  modport slave (
    input  dl_en, dl_addr, dl_data, dl_wr,
    output prog_addr, prog_data, prog_we
  );
endinterface

// File: rtl/jtdsp16_prog_loader.sv
// jtdsp16_prog_loader
// Turns the byte-wide system download stream into 16-bit writes on the DSP16
// internal-ROM programming port. Byte pairs are assembled into words, bytes
// outside the DSP ROM window are filtered, and the DSP is held in reset while
// a load is in progress.
// Ports:
//   clk       system clock
//   rst       synchronous reset, active-low
//   bus       download stream in (dl_*), ROM programming port out (prog_*)
//   dsp_rst   active-high reset to jtdsp16 until the image is complete
//   done      image complete; stays high until the next dl_en rise
//   ovf       sticky: an in-window byte beyond the 2^AW word ROM was dropped
//   checksum  modulo-2^16 sum of every word written through prog_we
module jtdsp16_prog_loader #(
  parameter logic [24:0] ROM_START = 25'h0,
  parameter bit          BIG_END   = 1'b1,
  parameter int          AW        = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  jtdsp16_prog_loader_if.slave        bus,
  output logic                        dsp_rst,
  output logic                        done,
  output logic                        ovf,
  output logic [15:0]                 checksum
);

  typedef enum logic [1:0] {IDLE, EMPTY, HALF, DONE} state_t;

  // Window size in bytes: two bytes per ROM word.
  localparam logic [24:0] WIN = 25'd2 << AW;

  state_t        state;
  logic          dl_en_p1;
  logic [7:0]    hold_byte;
  logic [AW-1:0] hold_idx;
  // Single-entry queue for an orphan odd byte that arrives while a held
  // half word still has to be flushed in the same cycle.
  logic          q_vld;
  logic [AW-1:0] q_idx;
  logic [15:0]   q_word;

  logic [24:0]   offs;
  logic          above;
  logic          in_win;
  logic          top_hit;
  logic          odd;
  logic          acc;
  logic          rise;
  logic [AW-1:0] idx;

  function automatic logic [15:0] pack_word(input logic [7:0] ev, input logic [7:0] od);
    if (BIG_END) return {ev, od};
    else         return {od, ev};
  endfunction

  assign offs    = bus.dl_addr - ROM_START;
  assign above   = bus.dl_addr >= ROM_START;
  assign in_win  = above && (offs < WIN);
  assign top_hit = above && !(offs < WIN);
  assign odd     = offs[0];
  assign idx     = offs[AW:1];
  assign acc     = bus.dl_wr & bus.dl_en;
  assign rise    = bus.dl_en & ~dl_en_p1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      // Treat dl_en as already high so that a session left running across
      // reset is only restarted by a genuine new rising edge.
      dl_en_p1      <= 1'b1;
      bus.prog_we   <= 1'b0;
      bus.prog_addr <= '0;
      bus.prog_data <= 16'h0;
      dsp_rst       <= 1'b1;
      done          <= 1'b0;
      ovf           <= 1'b0;
      checksum      <= 16'h0;
      hold_byte     <= 8'h0;
      hold_idx      <= '0;
      q_vld         <= 1'b0;
      q_idx         <= '0;
      q_word        <= 16'h0;
    end else begin
      dl_en_p1    <= bus.dl_en;
      bus.prog_we <= 1'b0;
      if (bus.prog_we) checksum <= checksum + bus.prog_data;

      case (state)
        IDLE: begin
          dsp_rst <= 1'b1;
          if (rise) begin
            state    <= EMPTY;
            done     <= 1'b0;
            ovf      <= 1'b0;
            checksum <= 16'h0;
          end
        end

        EMPTY: begin
          if (!bus.dl_en) begin
            if (q_vld) begin
              bus.prog_we   <= 1'b1;
              bus.prog_addr <= q_idx;
              bus.prog_data <= q_word;
            end
            q_vld   <= 1'b0;
            state   <= DONE;
            done    <= 1'b1;
            dsp_rst <= 1'b0;
          end else begin
            if (acc && top_hit) ovf <= 1'b1;
            // A queued orphan always takes this cycle's write slot.
            if (q_vld) begin
              bus.prog_we   <= 1'b1;
              bus.prog_addr <= q_idx;
              bus.prog_data <= q_word;
            end
            if (acc && in_win && !odd) begin
              hold_byte <= bus.dl_data;
              hold_idx  <= idx;
              q_vld     <= 1'b0;
              state     <= HALF;
            end else if (acc && in_win && odd) begin
              if (q_vld) begin
                q_idx  <= idx;
                q_word <= pack_word(8'h00, bus.dl_data);
              end else begin
                bus.prog_we   <= 1'b1;
                bus.prog_addr <= idx;
                bus.prog_data <= pack_word(8'h00, bus.dl_data);
              end
            end else begin
              q_vld <= 1'b0;
            end
          end
        end

        HALF: begin
          if (!bus.dl_en) begin
            bus.prog_we   <= 1'b1;
            bus.prog_addr <= hold_idx;
            bus.prog_data <= pack_word(hold_byte, 8'h00);
            state         <= DONE;
            done          <= 1'b1;
            dsp_rst       <= 1'b0;
          end else begin
            if (acc && top_hit) ovf <= 1'b1;
            if (acc && in_win) begin
              bus.prog_we   <= 1'b1;
              bus.prog_addr <= hold_idx;
              if (!odd) begin
                bus.prog_data <= pack_word(hold_byte, 8'h00);
                hold_byte     <= bus.dl_data;
                hold_idx      <= idx;
              end else if (idx == hold_idx) begin
                bus.prog_data <= pack_word(hold_byte, bus.dl_data);
                state         <= EMPTY;
              end else begin
                bus.prog_data <= pack_word(hold_byte, 8'h00);
                q_vld         <= 1'b1;
                q_idx         <= idx;
                q_word        <= pack_word(8'h00, bus.dl_data);
                state         <= EMPTY;
              end
            end
          end
        end

        DONE: begin
          if (rise) begin
            state    <= EMPTY;
            done     <= 1'b0;
            dsp_rst  <= 1'b1;
            ovf      <= 1'b0;
            checksum <= 16'h0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
